// File: rtl/tx_sched_if.sv
// Requester and transmitter signal bundle for tx_sched.
// The master side holds the character sources and the transmitter; the slave side is the scheduler.
interface tx_sched_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   ack;
    logic [7:0]           tx_data;
    logic                 tx_load;
    logic                 tx_enable;
    logic                 character_sent;

    modport master (
        output req, req_data, character_sent,
        input  ack, tx_data, tx_load, tx_enable
    );

    modport slave (
        input  req, req_data, character_sent,
        output ack, tx_data, tx_load, tx_enable
    );
endinterface

// File: rtl/tx_sched.sv
// Round-robin scheduler sharing one serial transmitter among NUM_REQ character sources.
//
// state | meaning
// IDLE  | waiting for any request; grants the first one at or after ptr
// LOAD  | tx_load held high for LOAD_CYCLES while the transmitter takes the byte
// SEND  | tx_enable high until a fresh rise of character_sent, or TIMEOUT cycles
// GAP   | enforced idle spacing of GAP_CYCLES (minimum one cycle) before IDLE
module tx_sched #(
    parameter int NUM_REQ     = 4,
    parameter int LOAD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int TIMEOUT     = 4096
) (
    input  logic       clk,
    input  logic       rst,
    tx_sched_if.slave  bus,
    output logic       busy,
    output logic [2:0] grant_idx,
    output logic       tx_error
);
    localparam int CNT_MAX  = (TIMEOUT > LOAD_CYCLES) ?
                              ((TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES) :
                              ((LOAD_CYCLES > GAP_CYCLES) ? LOAD_CYCLES : GAP_CYCLES);
    localparam int CW       = $clog2(CNT_MAX + 1);
    localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_GAP} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2:0]         ptr;
    logic               cs_prev;
    logic [NUM_REQ-1:0] req_rot;
    logic [2:0]         pick_off;
    logic [3:0]         pick_sum;
    logic [2:0]         pick;
    logic [7:0]         pick_data;
    logic [2:0]         next_ptr;
    logic               sent_edge;

    // Rotate requests so bit 0 is the ptr position; the lowest set bit wins.
    always_comb begin
        req_rot  = NUM_REQ'({bus.req, bus.req} >> ptr);
        pick_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) pick_off = 3'(k);
        end
        pick_sum = {1'b0, ptr} + {1'b0, pick_off};
        pick     = (pick_sum >= 4'(NUM_REQ)) ? 3'(pick_sum - 4'(NUM_REQ)) : pick_sum[2:0];
        pick_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick == 3'(k)) pick_data = bus.req_data[8*k +: 8];
        end
    end

    assign next_ptr  = (grant_idx == 3'(NUM_REQ - 1)) ? 3'd0 : grant_idx + 3'd1;
    // A level already high when SEND starts must fall and rise again to count.
    assign sent_edge = bus.character_sent & ~cs_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            ptr           <= '0;
            cs_prev       <= 1'b0;
            bus.ack       <= '0;
            bus.tx_data   <= '0;
            bus.tx_load   <= 1'b0;
            bus.tx_enable <= 1'b0;
            busy          <= 1'b0;
            grant_idx     <= '0;
            tx_error      <= 1'b0;
        end else begin
            cs_prev  <= bus.character_sent;
            bus.ack  <= '0;
            tx_error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|bus.req) begin
                        bus.tx_data <= pick_data;
                        grant_idx   <= pick;
                        bus.tx_load <= 1'b1;
                        busy        <= 1'b1;
                        cnt         <= CW'(LOAD_CYCLES - 1);
                        state       <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (cnt == '0) begin
                        bus.tx_load   <= 1'b0;
                        bus.tx_enable <= 1'b1;
                        cnt           <= CW'(TIMEOUT - 1);
                        state         <= S_SEND;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_SEND: begin
                    if (sent_edge || cnt == '0) begin
                        if (sent_edge) bus.ack <= NUM_REQ'(1) << grant_idx;
                        else           tx_error <= 1'b1;
                        bus.tx_enable <= 1'b0;
                        ptr           <= next_ptr;
                        cnt           <= CW'(GAP_LOAD);
                        state         <= S_GAP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_GAP: begin
                    if (cnt == '0) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tx_sched.sv
// Self-checking bench for tx_sched: vector table, reset/corner sequences, and random transfers
// checked against a transaction-level round-robin model.
module tb_tx_sched;
    localparam int N  = 4;
    localparam int LC = 4;
    localparam int GC = 2;
    localparam int TO = 50;

    logic       clk = 1'b0;
    logic       rst;
    logic       busy;
    logic [2:0] grant_idx;
    logic       tx_error;

    tx_sched_if #(.NUM_REQ(N)) bus();

    tx_sched #(.NUM_REQ(N), .LOAD_CYCLES(LC), .GAP_CYCLES(GC), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .grant_idx (grant_idx),
        .tx_error  (tx_error)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int m_ptr   = 0;

    typedef struct {
        logic [N-1:0]   r;
        logic [8*N-1:0] data;
        int             mode;   // 0 normal, 1 stale character_sent, 2 never sent
        int             d;
        bit             drop;
        int             g;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        logic [N-1:0] t;
        for (int k = 0; k < N; k++) begin
            t = r >> ((p + k) % N);
            if (t[0]) return (p + k) % N;
        end
        return -1;
    endfunction

    // One full transfer starting from IDLE at a falling edge; ends back in IDLE.
    task automatic run_xfer(input string tag, input logic [N-1:0] r, input logic [8*N-1:0] data,
                            input int mode, input int d, input bit drop, input int exp_g);
        logic [7:0]     exp_byte;
        logic [N-1:0]   exp_ack;
        logic [8*N-1:0] mask;
        int             load_len;
        int             en_len;
        int             gap_len;
        bit             en_in_load;
        bit             send_ok;
        exp_byte   = 8'(data >> (8 * exp_g));
        mask       = {{(8*N-8){1'b0}}, 8'hFF};
        en_in_load = 1'b0;
        send_ok    = 1'b1;
        bus.req            = r;
        bus.req_data       = data;
        bus.character_sent = 1'b0;
        @(negedge clk);
        check({tag, ".grant"}, 32'(grant_idx), exp_g);
        check({tag, ".data"}, 32'(bus.tx_data), 32'(exp_byte));
        check({tag, ".busy"}, 32'(busy), 1);
        load_len = 0;
        while (bus.tx_load && load_len < LC + 8) begin
            load_len++;
            if (bus.tx_enable) en_in_load = 1'b1;
            if (load_len == 1) begin
                bus.req_data = data ^ (mask << (8 * exp_g));
                if (drop) bus.req = r & ~(N'(1) << exp_g);
                if (mode == 1) bus.character_sent = 1'b1;
            end
            @(negedge clk);
        end
        check({tag, ".load_len"}, load_len, LC);
        check({tag, ".en_in_load"}, 32'(en_in_load), 0);
        en_len = 0;
        while (bus.tx_enable && en_len < TO + 8) begin
            en_len++;
            if (bus.tx_data !== exp_byte || bus.tx_load !== 1'b0 || bus.ack !== '0) send_ok = 1'b0;
            if (mode == 1 && en_len == 2) bus.character_sent = 1'b0;
            if (mode != 2 && en_len == d) bus.character_sent = 1'b1;
            @(negedge clk);
        end
        exp_ack = (mode == 2) ? '0 : N'(1) << exp_g;
        check({tag, ".en_len"}, en_len, (mode == 2) ? TO : d);
        check({tag, ".send_stable"}, 32'(send_ok), 1);
        check({tag, ".ack"}, 32'(bus.ack), 32'(exp_ack));
        check({tag, ".tx_error"}, 32'(tx_error), (mode == 2) ? 1 : 0);
        check({tag, ".data_hold"}, 32'(bus.tx_data), 32'(exp_byte));
        bus.character_sent = 1'b0;
        gap_len = 1;
        @(negedge clk);
        check({tag, ".pulse_end"}, {30'd0, tx_error, |bus.ack}, 0);
        while (busy && gap_len < GC + 8) begin
            gap_len++;
            @(negedge clk);
        end
        check({tag, ".gap_len"}, gap_len, GC);
        m_ptr = (exp_g + 1) % N;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0]   r;
        logic [8*N-1:0] data;
        int             mode;
        int             d;
        bit             drop;
        int             u;

        tbl[0]  = '{4'b1111, 32'h13121110, 0, 5, 1'b0, 0};
        tbl[1]  = '{4'b1111, 32'h13121110, 0, 5, 1'b0, 1};
        tbl[2]  = '{4'b1111, 32'h13121110, 0, 5, 1'b0, 2};
        tbl[3]  = '{4'b1111, 32'h13121110, 0, 5, 1'b0, 3};
        tbl[4]  = '{4'b1111, 32'h13121110, 0, 5, 1'b0, 0};
        tbl[5]  = '{4'b0001, 32'h13121155, 0, 20, 1'b0, 0};
        tbl[6]  = '{4'b0100, 32'h13121110, 1, 12, 1'b0, 2};
        tbl[7]  = '{4'b1010, 32'h13121110, 2, 0, 1'b0, 3};
        tbl[8]  = '{4'b1010, 32'h13121110, 0, 7, 1'b0, 1};
        tbl[9]  = '{4'b0110, 32'hA3B2C1D0, 0, 6, 1'b1, 2};
        tbl[10] = '{4'b0010, 32'hA3B2C1D0, 0, 3, 1'b0, 1};

        rst = 1'b1;
        bus.req = '0;
        bus.req_data = '0;
        bus.character_sent = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.busy", 32'(busy), 0);
        check("reset.outs", {bus.tx_data, 16'd0, grant_idx, bus.tx_load, bus.tx_enable, tx_error, 1'b0}, 0);
        check("reset.ack", 32'(bus.ack), 0);
        rst = 1'b0;
        m_ptr = 0;

        for (int i = 0; i < 11; i++) begin
            run_xfer($sformatf("row%0d", i), tbl[i].r, tbl[i].data, tbl[i].mode,
                     tbl[i].d, tbl[i].drop, tbl[i].g);
        end

        // Reset in the middle of SEND, then a fresh request must be picked from ptr=0.
        bus.req = 4'b0100;
        bus.req_data = 32'h77665544;
        for (int i = 0; i < 20 && !bus.tx_enable; i++) @(negedge clk);
        check("rst.reach_send", 32'(bus.tx_enable), 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst.busy", 32'(busy), 0);
        check("rst.tx_enable", 32'(bus.tx_enable), 0);
        check("rst.ack", 32'(bus.ack), 0);
        check("rst.outs", {bus.tx_data, 21'd0, grant_idx}, 0);
        rst = 1'b0;
        m_ptr = 0;
        run_xfer("rst_serve", 4'b1010, 32'h13124110, 0, 6, 1'b0, 1);

        for (int i = 0; i < 40; i++) begin
            r    = N'($urandom_range(1, (1 << N) - 1));
            data = (8*N)'({$urandom, $urandom});
            u    = $urandom_range(0, 9);
            mode = (u == 0) ? 2 : (u == 1) ? 1 : 0;
            d    = (mode == 1) ? $urandom_range(4, 30) : $urandom_range(1, 30);
            drop = ($urandom_range(0, 3) == 0);
            run_xfer($sformatf("rnd%0d", i), r, data, mode, d, drop, rr_pick(r, m_ptr));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
